// File: rtl/ir_nec_receiver.sv
`timescale 1ns/1ps
// ir_nec_receiver
//   NEC infrared frame decoder. The raw IR line is synchronized, and the
//   lengths of its active and idle phases are measured in oversampling
//   strobes. A frame is a start mark and space, then 32 data bits, then a
//   stop mark. The decoder checks this structure and the address and data
//   complement bytes, then reports the result.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   enable         decoder enable; low forces IDLE and suppresses all pulses
//   cfg_polarity   level of ir_in while the line is active (1 = active-high)
//   cfg_div        prescaler; one strobe every cfg_div+1 clocks
//   ir_in          raw IR line, asynchronous to clk
//   busy           a frame is in progress
//   frame_valid    1-clk pulse when a good frame has been decoded
//   frame_addr     address of the last good frame (held)
//   frame_data     data of the last good frame (held)
//   frame_error    1-clk pulse when a frame is aborted or fails the complement check
//
// Handshake: frame_valid and frame_error are single-cycle strobes with no
// back-pressure. frame_addr/frame_data are valid in the frame_valid cycle and
// hold their value until the next good frame.
module ir_nec_receiver #(
  parameter int OVERSAMPLE = 8,
  parameter int CNT_W      = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cfg_polarity,
  input  logic [15:0] cfg_div,
  input  logic        ir_in,
  output logic        busy,
  output logic        frame_valid,
  output logic [7:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic        frame_error
);

  // Width limits in strobes (T = OVERSAMPLE strobes).
  localparam logic [CNT_W-1:0] LIM_HALF = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] LIM_1P5  = CNT_W'(3 * OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] LIM_2    = CNT_W'(2 * OVERSAMPLE);
  localparam logic [CNT_W-1:0] LIM_4    = CNT_W'(4 * OVERSAMPLE);
  localparam logic [CNT_W-1:0] LIM_6    = CNT_W'(6 * OVERSAMPLE);
  localparam logic [CNT_W-1:0] LIM_10   = CNT_W'(10 * OVERSAMPLE);
  localparam logic [CNT_W-1:0] LIM_12   = CNT_W'(12 * OVERSAMPLE);
  localparam logic [CNT_W-1:0] LIM_20   = CNT_W'(20 * OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE, S_START_ACT, S_START_IDL, S_BIT_ACT, S_BIT_IDL, S_STOP_ACT, S_CHECK
  } state_t;

  state_t           state;
  logic             sync1, sync2, act_q;
  logic             act, rise, fall, act_edge, strobe;
  logic [15:0]      pcnt;
  logic [CNT_W-1:0] wcnt;
  logic [31:0]      sr;
  logic [4:0]       bcnt;

  function automatic logic in_rng(input logic [CNT_W-1:0] w,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  // The synchronizer resets to the idle level so that leaving reset never
  // looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= ~cfg_polarity;
      sync2 <= ~cfg_polarity;
      act_q <= 1'b0;
    end else begin
      sync1 <= ir_in;
      sync2 <= sync1;
      act_q <= act;
    end
  end

  assign act      = (sync2 == cfg_polarity);
  assign rise     = act & ~act_q;
  assign fall     = ~act & act_q;
  assign act_edge = rise | fall;
  assign strobe   = enable && !act_edge && (pcnt == cfg_div);

  // The prescaler restarts on every edge, so each phase is measured from a
  // clean strobe boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      wcnt <= '0;
    end else begin
      if (!enable || act_edge || (pcnt == cfg_div)) pcnt <= '0;
      else                                          pcnt <= pcnt + 16'd1;
      if (act_edge)                     wcnt <= '0;
      else if (strobe && (wcnt != '1))  wcnt <= wcnt + CNT_W'(1);
    end
  end

  // Edge-driven frame FSM. On an edge cycle wcnt still holds the width of the
  // phase that just ended. An edge is cleared on the next clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_addr  <= 8'h00;
      frame_data  <= 8'h00;
      sr          <= '0;
      bcnt        <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (!enable) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise) begin
              state <= S_START_ACT;
              bcnt  <= '0;
            end
          end
          S_START_ACT: begin
            if (fall) begin
              if (in_rng(wcnt, LIM_12, LIM_20)) state <= S_START_IDL;
              else begin frame_error <= 1'b1; state <= S_IDLE; end
            end else if (wcnt > LIM_20) begin
              frame_error <= 1'b1;
              state       <= S_IDLE;
            end
          end
          S_START_IDL: begin
            if (rise) begin
              if (in_rng(wcnt, LIM_6, LIM_10)) state <= S_BIT_ACT;
              else begin frame_error <= 1'b1; state <= S_IDLE; end
            end
          end
          S_BIT_ACT: begin
            if (fall) begin
              if (in_rng(wcnt, LIM_HALF, LIM_1P5)) state <= S_BIT_IDL;
              else begin frame_error <= 1'b1; state <= S_IDLE; end
            end else if (wcnt > LIM_1P5) begin
              frame_error <= 1'b1;
              state       <= S_IDLE;
            end
          end
          S_BIT_IDL: begin
            if (rise) begin
              // The space length encodes the bit; the rising edge that ends
              // it is also the mark of the next bit or of the stop.
              if (in_rng(wcnt, LIM_HALF, LIM_1P5) || in_rng(wcnt, LIM_2, LIM_4)) begin
                sr    <= {in_rng(wcnt, LIM_2, LIM_4), sr[31:1]};
                bcnt  <= bcnt + 5'd1;
                state <= (bcnt == 5'd31) ? S_STOP_ACT : S_BIT_ACT;
              end else begin
                frame_error <= 1'b1;
                state       <= S_IDLE;
              end
            end else if (wcnt > LIM_4) begin
              frame_error <= 1'b1;
              state       <= S_IDLE;
            end
          end
          S_STOP_ACT: begin
            if (fall) begin
              if (in_rng(wcnt, LIM_HALF, LIM_1P5)) state <= S_CHECK;
              else begin frame_error <= 1'b1; state <= S_IDLE; end
            end else if (wcnt > LIM_1P5) begin
              frame_error <= 1'b1;
              state       <= S_IDLE;
            end
          end
          S_CHECK: begin
            if ((sr[7:0] == ~sr[15:8]) && (sr[23:16] == ~sr[31:24])) begin
              frame_valid <= 1'b1;
              frame_addr  <= sr[7:0];
              frame_data  <= sr[23:16];
            end else begin
              frame_error <= 1'b1;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule
